// File: rtl/exam_ctrl_pkg.sv
// Shared types and helpers for the exam datapath sequencer/arbiter.
package exam_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SETTLE = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int WIDTH_DEF = 16;

    // Round-robin successor: the requester after ptr, wrapping at n.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/exam_arb_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: lowest request at or above ptr wins,
// otherwise the lowest request overall (wrap-around).
module rr_arbiter #(
    parameter int N   = 2,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_idx,
    output logic           any
);

    logic [N-1:0] mask;
    logic [N-1:0] masked;
    logic [N-1:0] pick_from;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        mask = '0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (i >= int'(ptr));
        end
    end

    assign masked    = req & mask;
    assign pick_from = (|masked) ? masked : req;
    assign any       = |req;

    // Descending scan so the lowest set bit is the last (winning) assignment.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pick_from[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                grant_idx = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/exam_arb_ctrl.sv
// Sequencer/arbiter sharing one exam register datapath between N_REQ
// requesters; each request is loaded, settled and returned as a tagged response.
module exam_arb_ctrl
    import exam_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int N_REQ = 2,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rest,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ-1:0]       req_inv,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [WIDTH-1:0]       rsp_data,
    output logic                   dp_ce,
    output logic                   dp_inv,
    output logic [WIDTH-1:0]       dp_data_in,
    input  logic [WIDTH-1:0]       dp_data_out,
    output logic                   busy,
    output logic [15:0]            txn_count
);

    state_t             state_q, state_d;
    logic [IDW-1:0]     ptr_q;
    logic [IDW-1:0]     id_q;
    logic               inv_q;
    logic [WIDTH-1:0]   word_q;
    logic [IDW-1:0]     rsp_id_q;
    logic [WIDTH-1:0]   rsp_data_q;
    logic [15:0]        txn_q;

    logic [N_REQ-1:0]   grant;
    logic [IDW-1:0]     grant_idx;
    logic               grant_any;
    logic               accept;
    logic               complete;

    rr_arbiter #(.N(N_REQ), .IDW(IDW)) u_arb (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    assign accept   = (state_q == IDLE) && grant_any;
    assign complete = (state_q == RESP) && rsp_ready;

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rest) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = LOAD;
            LOAD:                   state_d = SETTLE;
            SETTLE:                 state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Request latches, response capture, pointer and counter
    always_ff @(posedge clk) begin
        if (rest) begin
            ptr_q      <= '0;
            id_q       <= '0;
            inv_q      <= 1'b0;
            word_q     <= '0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
            txn_q      <= '0;
        end else begin
            if (accept) begin
                id_q   <= grant_idx;
                inv_q  <= req_inv[grant_idx];
                word_q <= req_data[grant_idx*WIDTH +: WIDTH];
            end
            if (state_q == SETTLE) begin
                rsp_data_q <= dp_data_out;
                rsp_id_q   <= id_q;
            end
            if (complete) begin
                ptr_q <= IDW'(rr_next(32'(id_q), N_REQ));
                txn_q <= txn_q + 16'd1;
            end
        end
    end

    // Output logic; dp_inv follows the latched flag for the whole transaction.
    always_comb begin
        req_ready = (state_q == IDLE) ? grant : '0;
        dp_ce     = (state_q == LOAD);
        dp_inv    = (state_q != IDLE) && inv_q;
        rsp_valid = (state_q == RESP);
        busy      = (state_q != IDLE);
    end

    assign dp_data_in = word_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;
    assign txn_count  = txn_q;

endmodule

// File: tb/tb_exam_arb_ctrl.sv
// Self-checking bench for exam_arb_ctrl with a behavioural exam register
// and a high-level round-robin / transaction reference model.
module tb_exam_arb_ctrl;

    localparam int N  = 2;
    localparam int W  = 16;
    localparam int IW = $clog2(N);

    logic           clk = 1'b0;
    logic           rest;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   req_inv;
    logic [N*W-1:0] req_data;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IW-1:0]  rsp_id;
    logic [W-1:0]   rsp_data;
    logic           dp_ce;
    logic           dp_inv;
    logic [W-1:0]   dp_data_in;
    logic [W-1:0]   dp_data_out;
    logic           busy;
    logic [15:0]    txn_count;

    exam_arb_ctrl #(.WIDTH(W), .N_REQ(N)) dut (
        .clk         (clk),
        .rest        (rest),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_inv     (req_inv),
        .req_data    (req_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .dp_ce       (dp_ce),
        .dp_inv      (dp_inv),
        .dp_data_in  (dp_data_in),
        .dp_data_out (dp_data_out),
        .busy        (busy),
        .txn_count   (txn_count)
    );

    always #5 clk = ~clk;

    // Behavioural exam register
    logic [W-1:0] exam_reg = '0;
    always @(posedge clk) if (dp_ce) exam_reg <= dp_data_in;
    assign dp_data_out = dp_inv ? ~exam_reg : exam_reg;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    int           ptr_m = 0;
    logic [15:0]  cnt_m = '0;
    logic [W-1:0] word_m [N];
    logic [N-1:0] inv_m;

    int nchk  = 0;
    int npass = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [N-1:0] vmask);
        req_valid = vmask;
        req_inv   = inv_m;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = word_m[i];
    endtask

    // One full transaction checked cycle by cycle; delay = cycles rsp_ready is held low in RESP.
    task automatic do_txn(input logic [N-1:0] vmask, input int delay, output int t_rsp);
        int           g;
        logic [N-1:0] exp_g;
        logic [W-1:0] exp_d;
        logic         exp_i;
        g = -1;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (ptr_m + k) % N;
            if (g < 0 && vmask[c]) g = c;
        end
        exp_g    = '0;
        exp_g[g] = 1'b1;
        exp_i    = inv_m[g];
        exp_d    = exp_i ? ~word_m[g] : word_m[g];
        drive_req(vmask);
        rsp_ready = (delay == 0);
        #1;
        nchk++; if (req_ready !== exp_g) $display("FAIL grant: got %b exp %b", req_ready, exp_g); else npass++;
        nchk++; if (busy !== 1'b0 || dp_ce !== 1'b0 || rsp_valid !== 1'b0) $display("FAIL idle_outs: busy %b ce %b rv %b exp 000", busy, dp_ce, rsp_valid); else npass++;
        step();
        nchk++; if (dp_ce !== 1'b1 || dp_data_in !== word_m[g] || dp_inv !== exp_i) $display("FAIL load: ce %b din %h inv %b exp 1 %h %b", dp_ce, dp_data_in, dp_inv, word_m[g], exp_i); else npass++;
        nchk++; if (req_ready !== '0 || busy !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL load_ctl: rdy %b busy %b rv %b exp 0 1 0", req_ready, busy, rsp_valid); else npass++;
        step();
        nchk++; if (dp_ce !== 1'b0 || dp_inv !== exp_i || rsp_valid !== 1'b0 || req_ready !== '0) $display("FAIL settle: ce %b inv %b rv %b rdy %b exp 0 %b 0 0", dp_ce, dp_inv, rsp_valid, req_ready, exp_i); else npass++;
        step();
        t_rsp = cyc;
        nchk++; if (rsp_valid !== 1'b1 || rsp_id !== IW'(g) || rsp_data !== exp_d) $display("FAIL resp: rv %b id %0d data %h exp 1 %0d %h", rsp_valid, rsp_id, rsp_data, g, exp_d); else npass++;
        for (int k = 1; k < delay; k++) begin
            step();
            nchk++; if (rsp_valid !== 1'b1 || rsp_id !== IW'(g) || rsp_data !== exp_d || dp_inv !== exp_i) $display("FAIL hold: rv %b id %0d data %h inv %b exp 1 %0d %h %b", rsp_valid, rsp_id, rsp_data, dp_inv, g, exp_d, exp_i); else npass++;
            nchk++; if (req_ready !== '0 || dp_ce !== 1'b0 || busy !== 1'b1) $display("FAIL hold_ctl: rdy %b ce %b busy %b exp 0 0 1", req_ready, dp_ce, busy); else npass++;
        end
        rsp_ready = 1'b1;
        step();
        cnt_m = cnt_m + 16'd1;
        ptr_m = (g + 1) % N;
        nchk++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || txn_count !== cnt_m) $display("FAIL done: rv %b busy %b cnt %h exp 0 0 %h", rsp_valid, busy, txn_count, cnt_m); else npass++;
        nchk++; if (dp_data_in !== word_m[g]) $display("FAIL din_hold: got %h exp %h", dp_data_in, word_m[g]); else npass++;
    endtask

    task automatic check_all_zero(input string tag);
        nchk++;
        if (req_ready !== '0 || rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_data !== '0 || dp_ce !== 1'b0 ||
            dp_inv !== 1'b0 || dp_data_in !== '0 || busy !== 1'b0 || txn_count !== '0)
            $display("FAIL %s: rdy %b rv %b id %0d data %h ce %b inv %b din %h busy %b cnt %h exp all 0",
                     tag, req_ready, rsp_valid, rsp_id, rsp_data, dp_ce, dp_inv, dp_data_in, busy, txn_count);
        else npass++;
    endtask

    task automatic test_reset();
        rest = 1'b1; req_valid = '0; req_inv = '0; req_data = '0; rsp_ready = 1'b0;
        step(); step();
        check_all_zero("reset");
        rest = 1'b0;
        ptr_m = 0; cnt_m = '0;
    endtask

    task automatic test_single();
        int t;
        word_m[0] = 16'hF0F0; inv_m = 2'b00;
        do_txn(2'b01, 0, t);
    endtask

    task automatic test_invert();
        int t;
        word_m[1] = 16'hF0F0; inv_m = 2'b10;
        do_txn(2'b10, 3, t);
    endtask

    task automatic test_idle();
        logic [15:0] c0;
        c0 = txn_count;
        req_valid = '0; rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            nchk++; if (busy !== 1'b0 || req_ready !== '0 || rsp_valid !== 1'b0 || txn_count !== c0) $display("FAIL idle: busy %b rdy %b rv %b cnt %h exp 0 0 0 %h", busy, req_ready, rsp_valid, txn_count, c0); else npass++;
        end
    endtask

    task automatic test_contention();
        int t_prev, t;
        logic [15:0] c0;
        c0 = cnt_m;
        word_m[0] = 16'hA5A5; word_m[1] = 16'h3C3C; inv_m = 2'b01;
        for (int k = 0; k < 4; k++) begin
            nchk++; if (ptr_m !== (k % 2)) $display("FAIL rr_order: txn %0d next %0d exp %0d", k, ptr_m, k % 2); else npass++;
            do_txn(2'b11, 0, t);
            if (k > 0) begin
                nchk++; if (t - t_prev !== 4) $display("FAIL spacing: got %0d exp 4", t - t_prev); else npass++;
            end
            t_prev = t;
        end
        nchk++; if (txn_count !== c0 + 16'd4) $display("FAIL cont_cnt: got %h exp %h", txn_count, c0 + 16'd4); else npass++;
    endtask

    task automatic test_backpressure();
        int t;
        word_m[0] = 16'h1357; inv_m = 2'b01;
        do_txn(2'b01, 10, t);
    endtask

    task automatic test_reset_mid();
        int t;
        word_m[0] = 16'h0FF0; inv_m = 2'b00;
        do_txn(2'b01, 0, t);
        word_m[1] = 16'h1234; inv_m = 2'b10;
        drive_req(2'b10);
        rsp_ready = 1'b0;
        step(); step();
        nchk++; if (dp_ce !== 1'b0 || busy !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL pre_rst: ce %b busy %b rv %b exp 0 1 0", dp_ce, busy, rsp_valid); else npass++;
        rest = 1'b1; req_valid = '0;
        step();
        check_all_zero("mid_reset");
        rest = 1'b0; rsp_ready = 1'b1;
        ptr_m = 0; cnt_m = '0;
        for (int k = 0; k < 5; k++) begin
            step();
            nchk++; if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL dropped: rv %b busy %b exp 0 0", rsp_valid, busy); else npass++;
        end
        word_m[0] = 16'h8001; word_m[1] = 16'h7FFE; inv_m = 2'b11;
        do_txn(2'b11, 0, t);
        do_txn(2'b10, 1, t);
    endtask

    task automatic test_random();
        int t;
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < N; i++) word_m[i] = W'($urandom);
            inv_m = N'($urandom);
            do_txn(N'($urandom_range(1, (1 << N) - 1)), int'($urandom_range(0, 3)), t);
        end
    endtask

    task automatic test_wrap();
        int t;
        dut.txn_q = 16'hFFFF;
        cnt_m     = 16'hFFFF;
        #1;
        nchk++; if (txn_count !== 16'hFFFF) $display("FAIL preload: got %h exp ffff", txn_count); else npass++;
        word_m[1] = 16'hBEEF; inv_m = 2'b00;
        do_txn(2'b10, 0, t);
        nchk++; if (txn_count !== 16'h0000) $display("FAIL wrap: got %h exp 0000", txn_count); else npass++;
    endtask

    initial begin
        word_m[0] = '0; word_m[1] = '0; inv_m = '0;
        test_reset();
        test_single();
        test_invert();
        test_idle();
        test_contention();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
